deserializer_align: RTL and testbench

- Parametrised multi-lane 10b serial-to-parallel receiver with per-lane K28.5 comma alignment and 8b/10b decode.
- Successor to the fixed 5-lane free-running deserializer. Adds a lane-count parameter, word-boundary detection, lock tracking and per-word valid strobes.
- Sits on the RX side of the F2F LVDS link, after the bit sampler (which supplies `strb`) and before the frame/packet layer.

---
 rtl/deser_pkg.sv | 21 ++
 rtl/dec_8b10b.sv | 80 ++++++++
 rtl/deser_lane.sv | 140 ++++++++++++++
 rtl/deserializer_align.sv | 53 +++++
 tb/tb_deserializer_align.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/deser_pkg.sv
// Shared constants and types for the aligning multi-lane 10b deserializer.
// Optional per-lane error counters are enabled with DESER_ERRCNT_EN.
package deser_pkg;

   localparam int WORD_W = 10;
   localparam int BYTE_W = 8;

   localparam logic [WORD_W-1:0] K28_5_RDN = 10'b0011111010;
   localparam logic [WORD_W-1:0] K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lane_state_t;

   function automatic logic is_comma(input logic [WORD_W-1:0] w);
      return (w == K28_5_RDN) || (w == K28_5_RDP);
   endfunction

endpackage

// File: rtl/dec_8b10b.sv
// Combinational 8b/10b sub-block decoder; bit 9 is 'a', bit 0 is 'j'.
// err flags any 6b or 4b sub-block outside the code tables.
module dec_8b10b (
   input  logic [9:0] code,
   output logic [7:0] data,
   output logic       err
);

   logic [5:0] six;
   logic [3:0] four;
   logic [4:0] edcba;
   logic [2:0] hgf;
   logic       err6;
   logic       err4;

   always_comb begin
      six   = code[9:4];
      // RD+ K28 control codes carry the complemented fghj group
      four  = (six == 6'b110000) ? ~code[3:0] : code[3:0];
      edcba = 5'd0;
      err6  = 1'b0;
      unique case (six)
         6'b100111, 6'b011000: edcba = 5'd0;
         6'b011101, 6'b100010: edcba = 5'd1;
         6'b101101, 6'b010010: edcba = 5'd2;
         6'b110001:            edcba = 5'd3;
         6'b110101, 6'b001010: edcba = 5'd4;
         6'b101001:            edcba = 5'd5;
         6'b011001:            edcba = 5'd6;
         6'b111000, 6'b000111: edcba = 5'd7;
         6'b111001, 6'b000110: edcba = 5'd8;
         6'b100101:            edcba = 5'd9;
         6'b010101:            edcba = 5'd10;
         6'b110100:            edcba = 5'd11;
         6'b001101:            edcba = 5'd12;
         6'b101100:            edcba = 5'd13;
         6'b011100:            edcba = 5'd14;
         6'b010111, 6'b101000: edcba = 5'd15;
         6'b011011, 6'b100100: edcba = 5'd16;
         6'b100011:            edcba = 5'd17;
         6'b010011:            edcba = 5'd18;
         6'b110010:            edcba = 5'd19;
         6'b001011:            edcba = 5'd20;
         6'b101010:            edcba = 5'd21;
         6'b011010:            edcba = 5'd22;
         6'b111010, 6'b000101: edcba = 5'd23;
         6'b110011, 6'b001100: edcba = 5'd24;
         6'b100110:            edcba = 5'd25;
         6'b010110:            edcba = 5'd26;
         6'b110110, 6'b001001: edcba = 5'd27;
         6'b001110:            edcba = 5'd28;
         6'b001111, 6'b110000: edcba = 5'd28;
         6'b101110, 6'b010001: edcba = 5'd29;
         6'b011110, 6'b100001: edcba = 5'd30;
         6'b101011, 6'b010100: edcba = 5'd31;
         default:              err6  = 1'b1;
      endcase
   end

   always_comb begin
      hgf  = 3'd0;
      err4 = 1'b0;
      unique case (four)
         4'b1011, 4'b0100: hgf = 3'd0;
         4'b1001:          hgf = 3'd1;
         4'b0101:          hgf = 3'd2;
         4'b1100, 4'b0011: hgf = 3'd3;
         4'b1101, 4'b0010: hgf = 3'd4;
         4'b1010:          hgf = 3'd5;
         4'b0110:          hgf = 3'd6;
         4'b1110, 4'b0001,
         4'b0111, 4'b1000: hgf = 3'd7;
         default:          err4 = 1'b1;
      endcase
   end

   assign data = {hgf, edcba};
   assign err  = err6 | err4;

endmodule

// File: rtl/deser_lane.sv
// One receive lane: shift register, bit counter, comma-alignment FSM
// and output register. Error counter present with DESER_ERRCNT_EN.
module deser_lane import deser_pkg::*; #(
   parameter int LOCK_COMMAS = 2,
   parameter int MISS_LIMIT  = 3
`ifdef DESER_ERRCNT_EN
   ,
   parameter int ERRW        = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial,
   input  logic              strb,
   output logic [BYTE_W-1:0] datout,
   output logic [WORD_W-1:0] encode,
   output logic              comma,
   output logic              valid,
   output logic              locked
`ifdef DESER_ERRCNT_EN
   ,
   output logic [ERRW-1:0]   err_cnt
`endif
);

   localparam logic [3:0] LC = 4'(LOCK_COMMAS);
   localparam logic [3:0] ML = 4'(MISS_LIMIT);

   lane_state_t       state, state_d;
   logic [WORD_W-1:0] sr, sr_d, shifted;
   logic [3:0]        cnt, cnt_d;
   logic [3:0]        acnt, acnt_d;
   logic [3:0]        miss, miss_d;
   logic              match, bnd, load_out;
   logic [BYTE_W-1:0] dec_data;
   logic              dec_err;

   dec_8b10b u_dec (
      .code (shifted),
      .data (dec_data),
      .err  (dec_err)
   );

   always_comb begin
      shifted  = {sr[WORD_W-2:0], serial};
      match    = is_comma(shifted);
      bnd      = (cnt == 4'd9);
      sr_d     = sr;
      cnt_d    = cnt;
      acnt_d   = acnt;
      miss_d   = miss;
      state_d  = state;
      load_out = 1'b0;
      if (strb) begin
         sr_d  = shifted;
         cnt_d = bnd ? 4'd0 : cnt + 4'd1;
         unique case (state)
            HUNT: begin
               if (match) begin
                  cnt_d   = 4'd0;
                  acnt_d  = 4'd1;
                  miss_d  = 4'd0;
                  state_d = (LC == 4'd1) ? LOCKED : CHECK;
               end
            end
            CHECK: begin
               if (bnd) begin
                  load_out = 1'b1;
                  if (match) begin
                     acnt_d = acnt + 4'd1;
                     if (acnt + 4'd1 >= LC) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                     end
                  end
               end else if (match) begin
                  cnt_d  = 4'd0;
                  acnt_d = 4'd1;
               end
            end
            LOCKED: begin
               if (bnd) begin
                  load_out = 1'b1;
                  if (match) miss_d = 4'd0;
               end else if (match) begin
                  // leave the counter alone so HUNT resumes from this phase
                  miss_d = miss + 4'd1;
                  if (miss + 4'd1 >= ML) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= HUNT;
         sr     <= '0;
         cnt    <= '0;
         acnt   <= '0;
         miss   <= '0;
         datout <= '0;
         encode <= '0;
         comma  <= 1'b0;
         valid  <= 1'b0;
         locked <= 1'b0;
      end else begin
         state  <= state_d;
         sr     <= sr_d;
         cnt    <= cnt_d;
         acnt   <= acnt_d;
         miss   <= miss_d;
         valid  <= load_out;
         locked <= (state_d == LOCKED);
         if (load_out) begin
            encode <= shifted;
            datout <= dec_data;
            comma  <= match;
         end
      end
   end

`ifdef DESER_ERRCNT_EN
   logic err_inc;

   assign err_inc = strb && (state == LOCKED) && (bnd ? dec_err : match);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= '0;
      else if (err_inc && (err_cnt != '1))
         err_cnt <= err_cnt + 1'b1;
   end
`else
   logic unused_dec_err;
   assign unused_dec_err = dec_err;
`endif

endmodule

// File: rtl/deserializer_align.sv
// Multi-lane 10b receiver with per-lane K28.5 alignment and 8b/10b decode.
// Define DESER_ERRCNT_EN to add the per-lane err_cnt output.
module deserializer_align import deser_pkg::*; #(
   parameter int LANES       = 5,
   parameter int LOCK_COMMAS = 2,
   parameter int MISS_LIMIT  = 3,
   parameter int ERRW        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LANES-1:0]        serial,
   input  logic                    strb,
   output logic [LANES*BYTE_W-1:0] datout,
   output logic [LANES*WORD_W-1:0] encode,
   output logic [LANES-1:0]        comma,
   output logic [LANES-1:0]        valid,
   output logic [LANES-1:0]        locked
`ifdef DESER_ERRCNT_EN
   ,
   output logic [LANES*ERRW-1:0]   err_cnt
`endif
);

`ifndef DESER_ERRCNT_EN
   localparam int unused_errw = ERRW;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      deser_lane #(
         .LOCK_COMMAS (LOCK_COMMAS),
         .MISS_LIMIT  (MISS_LIMIT)
`ifdef DESER_ERRCNT_EN
         ,
         .ERRW        (ERRW)
`endif
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .serial (serial[i]),
         .strb   (strb),
         .datout (datout[BYTE_W*i +: BYTE_W]),
         .encode (encode[WORD_W*i +: WORD_W]),
         .comma  (comma[i]),
         .valid  (valid[i]),
         .locked (locked[i])
`ifdef DESER_ERRCNT_EN
         ,
         .err_cnt (err_cnt[ERRW*i +: ERRW])
`endif
      );
   end

endmodule

// File: tb/tb_deserializer_align.sv
// Directed bench for deserializer_align: reset, lock, strb gating,
// loss of lock, multi-lane offsets and (with DESER_ERRCNT_EN) err_cnt.
module tb_deserializer_align;
   import deser_pkg::*;

   localparam int L  = 5;
   localparam int EW = 2;

   localparam logic [9:0] D21_5 = 10'b1010101010;
   localparam logic [9:0] D0_0  = 10'b1001110100;
   localparam logic [9:0] D3_6  = 10'b1100010110;
   localparam logic [9:0] D10_2 = 10'b0101010101;
   localparam logic [9:0] D17_1 = 10'b1000111001;

   logic           clk = 1'b0;
   logic           rst;
   logic [L-1:0]   serial;
   logic           strb;
   logic [L*8-1:0] datout;
   logic [L*10-1:0] encode;
   logic [L-1:0]   comma;
   logic [L-1:0]   valid;
   logic [L-1:0]   locked;
`ifdef DESER_ERRCNT_EN
   logic [L*EW-1:0] err_cnt;
`endif

   always #5 clk = ~clk;

   deserializer_align #(
      .LANES       (L),
      .LOCK_COMMAS (2),
      .MISS_LIMIT  (3),
      .ERRW        (EW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .serial (serial),
      .strb   (strb),
      .datout (datout),
      .encode (encode),
      .comma  (comma),
      .valid  (valid),
      .locked (locked)
`ifdef DESER_ERRCNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   typedef struct {
      logic [9:0] w;
      int         dv;
      logic [7:0] dat;
      logic       com;
      logic       lck;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         lastv = 0;
   int         vcnt[L];
   logic [7:0] last_dat[L];
   int         gapq[$];
   logic [7:0] datq[$];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input logic [L-1:0] b, input logic s);
      @(negedge clk);
      cyc++;
      for (int i = 0; i < L; i++) begin
         if (valid[i]) begin
            vcnt[i]++;
            last_dat[i] = datout[8*i +: 8];
            if (i == 0) begin
               gapq.push_back(cyc - lastv);
               lastv = cyc;
               datq.push_back(datout[7:0]);
            end
         end
      end
      serial = b;
      strb   = s;
   endtask

   task automatic idle();
      tick('0, 1'b0);
   endtask

   task automatic word_all(input logic [9:0] w);
      for (int k = 9; k >= 0; k--) tick({L{w[k]}}, 1'b1);
   endtask

   task automatic clr_counts();
      for (int i = 0; i < L; i++) begin
         vcnt[i]     = 0;
         last_dat[i] = 8'h00;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[6];
      logic [9:0] dw[L];
      logic [7:0] dexp[L];
      logic [33:0] st[L];
      logic [L-1:0] b;
      int         v0;

      tbl[0] = '{D21_5,     1, 8'hB5, 1'b0, 1'b0};
      tbl[1] = '{K28_5_RDN, 1, 8'hBC, 1'b1, 1'b1};
      tbl[2] = '{D21_5,     1, 8'hB5, 1'b0, 1'b1};
      tbl[3] = '{D0_0,      1, 8'h00, 1'b0, 1'b1};
      tbl[4] = '{K28_5_RDP, 1, 8'hBC, 1'b1, 1'b1};
      tbl[5] = '{D3_6,      1, 8'hC3, 1'b0, 1'b1};
      dw   = '{D21_5, D0_0, D3_6, D10_2, D17_1};
      dexp = '{8'hB5, 8'h00, 8'hC3, 8'h4A, 8'h31};

      rst    = 1'b1;
      serial = '0;
      strb   = 1'b0;
      clr_counts();
      for (int k = 0; k < 10; k++) tick(L'($urandom), k[0]);
      chk("rst_datout", datout, 0);
      chk("rst_encode", encode, 0);
      chk("rst_comma", comma, 0);
      chk("rst_valid", valid, 0);
      chk("rst_locked", locked, 0);
      rst = 1'b0;
      clr_counts();

      for (int k = 0; k < 50; k++) tick({L{~k[0]}}, 1'b1);
      idle();
      chk("nocomma_valid", vcnt[0], 0);
      chk("nocomma_locked", locked, 0);

      for (int k = 0; k < 3; k++) tick('0, 1'b1);
      word_all(K28_5_RDN);
      idle();
      chk("hunt_comma_valid", vcnt[0], 0);
      chk("hunt_comma_locked", locked[0], 0);

      for (int n = 0; n < 6; n++) begin
         v0 = vcnt[0];
         word_all(tbl[n].w);
         idle();
         chk($sformatf("tbl%0d_valid", n), vcnt[0] - v0, tbl[n].dv);
         chk($sformatf("tbl%0d_dat", n), datout[7:0], tbl[n].dat);
         chk($sformatf("tbl%0d_comma", n), comma[0], tbl[n].com);
         chk($sformatf("tbl%0d_locked", n), locked[0], tbl[n].lck);
      end

      gapq.delete();
      datq.delete();
      v0 = vcnt[0];
      word_all(D21_5);
      for (int k = 9; k >= 0; k--) begin
         tick({L{D0_0[k]}}, 1'b1);
         if (k == 5) repeat (7) tick('0, 1'b0);
      end
      word_all(D3_6);
      idle();
      chk("gate_nvalid", vcnt[0] - v0, 3);
      chk("gate_gap_stretch", gapq.size() > 1 ? gapq[1] : -1, 17);
      chk("gate_gap_normal", gapq.size() > 2 ? gapq[2] : -1, 10);
      chk("gate_word", datq.size() > 1 ? datq[1] : 8'hFF, 8'h00);
      chk("gate_locked", locked[0], 1);

      tick('0, 1'b1);
      word_all(K28_5_RDN);
      word_all(K28_5_RDN);
      idle();
      chk("miss2_locked", locked[0], 1);
      word_all(K28_5_RDN);
      idle();
      chk("miss3_unlocked", locked[0], 0);

      word_all(K28_5_RDN);
      word_all(K28_5_RDN);
      idle();
      chk("relock", locked[0], 1);
      tick('0, 1'b1);
      word_all(K28_5_RDN);
      word_all(K28_5_RDN);
      repeat (9) tick('0, 1'b1);
      word_all(K28_5_RDN);
      tick('0, 1'b1);
      word_all(K28_5_RDN);
      word_all(K28_5_RDN);
      idle();
      chk("miss_cleared_hold", locked[0], 1);

      for (int k = 0; k < 4; k++) tick('1, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_locked", locked, 0);
      chk("rst_async_valid", valid, 0);
      idle();
      rst = 1'b0;
      clr_counts();

      for (int i = 0; i < L; i++)
         st[i] = 34'({K28_5_RDN, K28_5_RDN, dw[i]}) << (4 - i);
      for (int t = 33; t >= 0; t--) begin
         for (int i = 0; i < L; i++) b[i] = st[i][t];
         tick(b, 1'b1);
      end
      idle();
      for (int i = 0; i < L; i++) begin
         chk($sformatf("ml%0d_locked", i), locked[i], 1);
         chk($sformatf("ml%0d_nvalid", i), vcnt[i], 2);
         chk($sformatf("ml%0d_dat", i), last_dat[i], dexp[i]);
      end
      chk("ml4_datout_slice", datout[39:32], 8'h31);

`ifdef DESER_ERRCNT_EN
      rst = 1'b1;
      idle();
      rst = 1'b0;
      word_all(K28_5_RDN);
      word_all(K28_5_RDN);
      idle();
      chk("ec_locked", locked[0], 1);
      word_all(10'b0000000000);
      idle();
      chk("ec_one", err_cnt[EW-1:0], 1);
      repeat (4) word_all(10'b0000000000);
      idle();
      chk("ec_sat0", err_cnt[EW-1:0], 3);
      chk("ec_sat4", err_cnt[4*EW +: EW], 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
